upsample_2d: RTL and testbench

// - Nearest-neighbour 2D upsampler for 8-bit pixel streams (disparity/grey maps).
// - Replicates each input pixel dec_factor times horizontally and each input row
//   dec_factor times vertically. Restores display resolution after decimated processing.
// - Sits between the downstream end of the disparity filters and the output/display path.
// - One-row line buffer; valid/ready on both sides.

---
 rtl/upsample_2d.sv | 181 ++++++++++++++++++
 tb/tb_upsample_2d.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/upsample_2d.sv
// upsample_2d: nearest-neighbour 2D upsampler with a one-row line buffer.
// Defining UPSAMPLE_EOL_EN adds the registered out_eol/out_eof row and frame markers.
module upsample_2d #(
  parameter int dec_factor = 2,
  parameter int in_width   = 120,
  parameter int in_height  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
`ifdef UPSAMPLE_EOL_EN
  ,
  output logic       out_eol,
  output logic       out_eof
`endif
);

  localparam int COL_W = (in_width > 1) ? $clog2(in_width) : 1;
  localparam int REP_W = (dec_factor > 1) ? $clog2(dec_factor) : 1;
  localparam int ROW_W = (in_height > 1) ? $clog2(in_height) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(in_width - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(dec_factor - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(in_height - 1);

  typedef enum logic {FILL = 1'b0, REPLAY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [REP_W-1:0] rep_x_q, rep_x_d;
  logic [REP_W-1:0] rep_y_q, rep_y_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             last_col_q, last_col_d;
  logic [7:0]       line_q [0:in_width-1];

  logic             hs_s, last_rep_s, in_ready_s, accept_s, rd_load_s;
  logic [COL_W-1:0] col_inc_s;
  logic [ROW_W-1:0] row_inc_s;

  assign hs_s       = out_valid_q && out_ready;
  assign last_rep_s = (rep_x_q == REP_LAST);
  assign col_inc_s  = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
  assign row_inc_s  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
  // The last pixel of a row blocks new input so the row can be replayed from the buffer.
  assign in_ready_s = !reset && (state_q == FILL) &&
                      (!out_valid_q || (out_ready && last_rep_s && !last_col_q));
  assign accept_s   = in_valid && in_ready_s;
  assign rd_load_s  = (state_q == REPLAY) &&
                      (!out_valid_q || (hs_s && last_rep_s && !last_col_q));

  // Next-state logic for the fill/replay sequencer and the output register.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rep_x_d     = rep_x_q;
    rep_y_d     = rep_y_q;
    row_d       = row_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_col_d  = last_col_q;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          rep_x_d     = '0;
          last_col_d  = (col_q == COL_LAST);
          col_d       = col_inc_s;
        end else if (hs_s) begin
          if (!last_rep_s) begin
            rep_x_d = rep_x_q + REP_W'(1);
          end else begin
            out_valid_d = 1'b0;
            if (last_col_q) begin
              state_d = REPLAY;
              rep_y_d = REP_W'(1);
              col_d   = '0;
            end else begin
              state_d = FILL;
            end
          end
        end else begin
          state_d = FILL;
        end
      end
      REPLAY: begin
        if (rd_load_s) begin
          out_data_d  = line_q[col_q];
          out_valid_d = 1'b1;
          rep_x_d     = '0;
          last_col_d  = (col_q == COL_LAST);
          col_d       = col_inc_s;
        end else if (hs_s) begin
          if (!last_rep_s) begin
            rep_x_d = rep_x_q + REP_W'(1);
          end else begin
            // End of a replayed row; the next row start is the one bubble cycle.
            out_valid_d = 1'b0;
            if (rep_y_q != REP_LAST) begin
              rep_y_d = rep_y_q + REP_W'(1);
            end else begin
              rep_y_d = '0;
              row_d   = row_inc_s;
              state_d = FILL;
            end
          end
        end else begin
          state_d = REPLAY;
        end
      end
      default: begin
        state_d     = FILL;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      col_q       <= '0;
      rep_x_q     <= '0;
      rep_y_q     <= '0;
      row_q       <= '0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      last_col_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      rep_x_q     <= rep_x_d;
      rep_y_q     <= rep_y_d;
      row_q       <= row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_col_q  <= last_col_d;
    end
  end

  // Line buffer write port: each accepted pixel lands at its column.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_q[col_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef UPSAMPLE_EOL_EN
  logic out_eol_q, out_eol_d;
  logic out_eof_q, out_eof_d;

  assign out_eol_d = out_valid_d && last_col_d && (rep_x_d == REP_LAST);
  assign out_eof_d = out_eol_d && (state_q == REPLAY) &&
                     (row_q == ROW_LAST) && (rep_y_q == REP_LAST);

  // Row/frame markers travel with the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_eol_q <= 1'b0;
      out_eof_q <= 1'b0;
    end else begin
      out_eol_q <= out_eol_d;
      out_eof_q <= out_eof_d;
    end
  end

  assign out_eol = out_eol_q;
  assign out_eof = out_eof_q;
`endif

endmodule

// File: tb/tb_upsample_2d.sv
// Scoreboard bench for upsample_2d: a 2x/4x2 instance for the main scenarios and a
// 3x/3x1 instance for the odd replication factor.
module tb_upsample_2d;

  localparam int DEC = 2;
  localparam int W   = 4;
  localparam int H   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
`ifdef UPSAMPLE_EOL_EN
  logic       a_out_eol, a_out_eof, b_out_eol, b_out_eof;
`endif

  always #5 clk = ~clk;

  upsample_2d #(.dec_factor(DEC), .in_width(W), .in_height(H)) dut_a (
    .clk(clk), .reset(reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef UPSAMPLE_EOL_EN
    , .out_eol(a_out_eol), .out_eof(a_out_eof)
`endif
  );

  upsample_2d #(.dec_factor(3), .in_width(3), .in_height(1)) dut_b (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef UPSAMPLE_EOL_EN
    , .out_eol(b_out_eol), .out_eof(b_out_eof)
`endif
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q [$];
  logic [7:0] rowbuf [0:W-1];
  int         m_col, m_row, n_out, idle;
  bit         acc, hs, prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // Reference model: each accepted pixel yields DEC copies; a completed row is replayed DEC-1 times.
  task automatic model_accept(input logic [7:0] d);
    rowbuf[m_col] = d;
    for (int r = 0; r < DEC; r++)
      exp_q.push_back({1'b0, 1'((m_col == W-1) && (r == DEC-1)), d});
    if (m_col == W-1) begin
      for (int y = 1; y < DEC; y++)
        for (int c = 0; c < W; c++)
          for (int r = 0; r < DEC; r++)
            exp_q.push_back({1'((m_row == H-1) && (y == DEC-1) && (c == W-1) && (r == DEC-1)),
                             1'((c == W-1) && (r == DEC-1)), rowbuf[c]});
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic cycle_a(input bit iv, input bit ordy, input logic [7:0] d);
    logic [9:0] e;
    @(negedge clk);
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_valid", a_out_valid, 1);
      chk("hold_data", a_out_data, prev_data);
    end
    hs  = a_out_valid && a_out_ready;
    acc = a_in_valid && a_in_ready;
    if (!a_out_valid && exp_q.size() > 0) idle++;
    if (acc) chk("accept_while_pending", exp_q.size() - (hs ? 1 : 0), 0);
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", a_out_data, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("data", a_out_data, e[7:0]);
`ifdef UPSAMPLE_EOL_EN
        chk("eol", a_out_eol, e[8]);
        chk("eof", a_out_eof, e[9]);
`endif
        n_out++;
      end
    end
    if (acc) model_accept(a_in_data);
    prev_stall = a_out_valid && !a_out_ready;
    prev_data  = a_out_data;
  endtask

  task automatic run_a(input int npix, input int base, input int piv, input int por,
                       input int exp_out, input int exp_idle);
    int sent = 0;
    int cyc  = 0;
    n_out = 0;
    idle  = 0;
    while ((sent < npix || exp_q.size() > 0) && cyc < 3000) begin
      cycle_a((sent < npix) && rnd(piv), rnd(por), 8'(base + sent));
      if (acc) sent++;
      cyc++;
    end
    chk("out_count", n_out, exp_out);
    chk("leftover", exp_q.size(), 0);
    if (exp_idle >= 0) chk("bubbles", idle, exp_idle);
    for (int i = 0; i < 4; i++) cycle_a(1'b0, 1'b1, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_col      = 0;
    m_row      = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    logic [7:0] b_q [$];
    int         cnt, cyc, b_n, b_idle, b_sent;
    reset       = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 8'd0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = 8'd0;
    b_out_ready = 1'b1;
    m_col       = 0;
    m_row       = 0;
    prev_stall  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", a_out_valid, 0);
    chk("reset_out_data", a_out_data, 0);
    chk("reset_in_ready", a_in_ready, 0);
    @(negedge clk);
    reset      = 1'b0;
    a_in_valid = 1'b0;

    // Full-rate frame, random handshakes, then two frames back to back.
    run_a(8, 1, 100, 100, 32, 2);
    run_a(8, 1, 50, 50, 32, -1);
    run_a(16, 21, 100, 100, 64, 4);

    // Reset after two accepted pixels, then a fresh frame.
    cnt = 0;
    cyc = 0;
    while (cnt < 2 && cyc < 50) begin
      cycle_a(1'b1, 1'b1, 8'(60 + cnt));
      if (acc) cnt++;
      cyc++;
    end
    chk("pre_reset_accepts", cnt, 2);
    do_reset();
    cycle_a(1'b0, 1'b1, 8'd0);
    chk("post_reset_valid", a_out_valid, 0);
    run_a(8, 9, 100, 100, 32, 2);

    // Replication factor 3: three copies of the row 1,1,1,2,2,2,3,3,3.
    for (int y = 0; y < 3; y++)
      for (int p = 1; p <= 3; p++)
        for (int r = 0; r < 3; r++) b_q.push_back(8'(p));
    b_n    = 0;
    b_idle = 0;
    b_sent = 0;
    cyc    = 0;
    while ((b_sent < 3 || b_q.size() > 0) && cyc < 200) begin
      @(negedge clk);
      b_in_valid  = (b_sent < 3);
      b_in_data   = 8'(b_sent + 1);
      b_out_ready = 1'b1;
      #1;
      if (!b_out_valid && b_q.size() > 0 && b_n > 0) b_idle++;
      if (b_out_valid) begin
        if (b_q.size() == 0) chk("b_unexpected_out", b_out_data, 32'hFFFF_FFFF);
        else begin
          chk("b_data", b_out_data, b_q.pop_front());
          b_n++;
        end
      end
      if (b_in_valid && b_in_ready) b_sent++;
      cyc++;
    end
    b_in_valid = 1'b0;
    chk("b_out_count", b_n, 27);
    chk("b_bubbles", b_idle, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
